// File: rtl/ascii_to_bcd_stream.sv
// ascii_to_bcd_stream: packs a stream of ASCII decimal characters into packed-BCD words
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_char character input;
//        out_valid/out_ready with bcd, digit_count, err as the completed-word output.
module ascii_to_bcd_stream #(
  parameter int NDIG = 4,
  parameter logic [7:0] TERM_CHAR = 8'h0D
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [7:0]                 in_char,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [4*NDIG-1:0]          bcd,
  output logic [$clog2(NDIG+1)-1:0]  digit_count,
  output logic                       err
);
  localparam int CW = $clog2(NDIG + 1);
  typedef enum logic {COLLECT, OUT} state_t;
  state_t state;
  logic is_digit, is_term;
  assign is_digit = (in_char >= 8'h30) && (in_char <= 8'h39);
  assign is_term = (in_char == TERM_CHAR) || (in_char == 8'h20);
  // bcd/digit_count/err double as accumulator, digit count and error-pending flag.
  // An invalid character zeroes bcd and digit_count and later digits are discarded,
  // so an error word always leaves with bcd=0 and digit_count=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COLLECT;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      bcd <= '0;
      digit_count <= '0;
      err <= 1'b0;
    end else if (state == OUT) begin
      if (out_ready) begin
        state <= COLLECT;
        in_ready <= 1'b1;
        out_valid <= 1'b0;
        bcd <= '0;
        digit_count <= '0;
        err <= 1'b0;
      end
    end else if (in_valid) begin
      if (is_digit) begin
        if (!err) begin
          bcd <= {bcd[4*NDIG-5:0], in_char[3:0]};
          digit_count <= digit_count + 1'b1;
          if (digit_count == CW'(NDIG - 1)) begin
            state <= OUT;
            in_ready <= 1'b0;
            out_valid <= 1'b1;
          end
        end
      end else if (is_term) begin
        // a terminator on an empty, error-free word is ignored to collapse blank runs
        if (digit_count != '0 || err) begin
          state <= OUT;
          in_ready <= 1'b0;
          out_valid <= 1'b1;
        end
      end else begin
        err <= 1'b1;
        bcd <= '0;
        digit_count <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ascii_to_bcd_stream.sv
// tb_ascii_to_bcd_stream: directed table, corner sequences and randomized stream vs a word-level model
module tb_ascii_to_bcd_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_char = 8'h00;
  logic in_ready, out_valid;
  logic out_ready = 1'b0;
  logic [15:0] bcd;
  logic [2:0] digit_count;
  logic err;
  int vectors = 0;
  int miscompares = 0;

  ascii_to_bcd_stream #(.NDIG(4), .TERM_CHAR(8'h0D)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_char(in_char), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .bcd(bcd), .digit_count(digit_count), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {logic [15:0] b; int c; bit e;} word_t;
  word_t exp_q[$];
  int digits[$];
  bit merr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void emit();
    word_t w;
    w.b = 16'h0;
    w.c = 0;
    w.e = merr;
    if (!merr) begin
      foreach (digits[i]) w.b = w.b * 16 + 16'(digits[i]);
      w.c = digits.size();
    end
    exp_q.push_back(w);
    digits.delete();
    merr = 1'b0;
  endfunction

  function automatic void model_feed(input logic [7:0] c);
    if (c >= "0" && c <= "9") begin
      if (!merr) begin
        digits.push_back(int'(c) - int'("0"));
        if (digits.size() == 4) emit();
      end
    end else if (c == 8'h0D || c == 8'h20) begin
      if (digits.size() > 0 || merr) emit();
    end else begin
      merr = 1'b1;
      digits.delete();
    end
  endfunction

  // scoreboard: every word taken must match the oldest word the model produced
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      digits.delete();
      merr = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", {bcd, digit_count, err}, 32'hFFFF_FFFF);
        else begin
          word_t w;
          w = exp_q.pop_front();
          chk("model_word", {bcd, 5'(digit_count), err}, {w.b, 5'(w.c), w.e});
        end
      end
      if (in_valid && in_ready) model_feed(in_char);
    end
  end

  // present one character ('~' stands for TERM_CHAR); returns one step after the accepting edge
  task automatic send(input logic [7:0] c);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_char = (c == "~") ? 8'h0D : c;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic take();
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic expect_word(input logic [15:0] b, input int c, input bit e, input string name);
    @(negedge clk);
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_in_ready"}, in_ready, 0);
    chk({name, "_bcd"}, bcd, b);
    chk({name, "_count"}, digit_count, c);
    chk({name, "_err"}, err, e);
    take();
  endtask

  task automatic expect_none(input string name);
    repeat (3) begin
      @(negedge clk);
      chk(name, out_valid, 0);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rand_char();
    int r = $urandom_range(0, 9);
    if (r <= 5) return 8'h30 + 8'($urandom_range(0, 9));
    if (r == 6) return 8'h0D;
    if (r == 7) return 8'h20;
    if (r == 8) return 8'h80 + 8'($urandom_range(0, 127));
    return 8'h3A + 8'($urandom_range(0, 5));
  endfunction

  typedef struct {logic [63:0] s; int n; bit has; logic [15:0] b; int c; bit e;} vec_t;
  vec_t tbl[9];

  initial begin
    tbl[0] = '{"1234", 4, 1, 16'h1234, 4, 0};
    tbl[1] = '{"~", 1, 0, 16'h0, 0, 0};
    tbl[2] = '{"70~", 3, 1, 16'h0070, 2, 0};
    tbl[3] = '{"  ", 2, 0, 16'h0, 0, 0};
    tbl[4] = '{"5A9~", 4, 1, 16'h0, 0, 1};
    tbl[5] = '{"42~", 3, 1, 16'h0042, 2, 0};
    tbl[6] = '{"0 ", 2, 1, 16'h0000, 1, 0};
    tbl[7] = '{"9:~", 3, 1, 16'h0, 0, 1};
    tbl[8] = '{"~ ~", 3, 0, 16'h0, 0, 0};
    #12;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_bcd", bcd, 0);
    chk("reset_count", digit_count, 0);
    chk("reset_err", err, 0);
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;
    foreach (tbl[k]) begin
      for (int i = 0; i < tbl[k].n; i++) send(tbl[k].s[8*(tbl[k].n-1-i) +: 8]);
      if (tbl[k].has) expect_word(tbl[k].b, tbl[k].c, tbl[k].e, $sformatf("tbl%0d", k));
      else expect_none($sformatf("tbl%0d_none", k));
    end
    // backpressure: word held stable, next character held until the word is taken
    send("9"); send("8"); send("7"); send("6");
    in_valid = 1'b1;
    in_char = "1";
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_bcd", bcd, 16'h9876);
      chk("hold_in_ready", in_ready, 0);
    end
    take();
    @(negedge clk);
    chk("hold_resume_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    send("~");
    expect_word(16'h0001, 1, 0, "held_char");
    // asynchronous reset mid-word
    send("1"); send("2");
    #3 rst_n = 1'b0;
    #1;
    chk("arst_mid_bcd", bcd, 0);
    chk("arst_mid_count", digit_count, 0);
    chk("arst_mid_ready", in_ready, 1);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    // asynchronous reset during output
    send("1"); send("2"); send("3"); send("4");
    @(negedge clk);
    chk("arst_out_pre", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_ready", in_ready, 1);
    chk("arst_out_bcd", bcd, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send("3"); send("~");
    expect_word(16'h0003, 1, 0, "post_reset");
    // randomized stream against the model
    begin
      bit acc_now;
      for (int k = 0; k < 4000; k++) begin
        @(negedge clk);
        acc_now = in_valid && in_ready;
        @(posedge clk);
        #1;
        out_ready = ($urandom_range(0, 3) != 0);
        if (!in_valid || acc_now) begin
          in_valid = ($urandom_range(0, 3) != 0);
          in_char = rand_char();
        end
      end
    end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    send("~");
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("drain_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
